// File: rtl/ttt_move_entry_if.sv
// Move-request handshake between the player-side entry controller (master)
// and the tic-tac-toe game core (slave). Four-phase req/ack: the master
// holds MoveReq with a stable MoveCell/MovePlayer until MoveAck rises, then
// waits for MoveAck to fall before it may request again.
interface ttt_move_entry_if;
   logic       MoveReq;
   logic       MoveAck;
   logic [3:0] MoveCell;
   logic       MovePlayer;

   modport master (output MoveReq, output MoveCell, output MovePlayer, input MoveAck);
   modport slave  (input MoveReq, input MoveCell, input MovePlayer, output MoveAck);
endinterface

// File: rtl/ttt_move_entry.sv
// Player-side move entry controller for the tic-tac-toe game core.
// Button pulses move a 3x3 cursor; BtnC on a free cell issues a four-phase
// move request carrying the cell index 3*y+x and the player to move.
// Optional build macro CURSOR_SKIP_EN: cursor steps jump over occupied cells
// along the row/column, and entry from IDLE avoids an occupied centre.
module ttt_move_entry #(
   parameter int TIMEOUT_CYC = 1023,
   parameter int TO_W        = 10
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Enable,
   input  logic               Turn,
   input  logic [8:0]         Occupied,
   input  logic               BtnU,
   input  logic               BtnD,
   input  logic               BtnL,
   input  logic               BtnR,
   input  logic               BtnC,
   ttt_move_entry_if.master   mv,
   output logic [1:0]         CurX,
   output logic [1:0]         CurY,
   output logic               Reject,
   output logic               Timeout,
   output logic               Qidle,
   output logic               Qsel,
   output logic               Qreq,
   output logic               Qrel
);

   // One-hot encoding so the Q flags are direct register bits.
   typedef enum logic [3:0] {
      ST_IDLE = 4'b1000,
      ST_SEL  = 4'b0100,
      ST_REQ  = 4'b0010,
      ST_REL  = 4'b0001
   } state_t;

   state_t          state;
   logic [TO_W-1:0] to_cnt;
   logic [1:0]      nxt_x;
   logic [1:0]      nxt_y;
   logic [1:0]      ent_x;
   logic [1:0]      ent_y;
   logic [3:0]      cur_cell;

   // Step forward around 0,1,2.
   function automatic logic [1:0] wrap_inc(input logic [1:0] v);
      return (v == 2'd2) ? 2'd0 : v + 2'd1;
   endfunction

   // Step backward around 0,1,2.
   function automatic logic [1:0] wrap_dec(input logic [1:0] v);
      return (v == 2'd0) ? 2'd2 : v - 2'd1;
   endfunction

   // Board index 3*y + x, computed as 2y + y + x.
   function automatic logic [3:0] cell_idx(input logic [1:0] x, input logic [1:0] y);
      return ({2'b00, y} << 1) + {2'b00, y} + {2'b00, x};
   endfunction

`ifdef CURSOR_SKIP_EN
   // Occupancy of row y, bit k = column k.
   function automatic logic [2:0] row_bits(input logic [8:0] occ, input logic [1:0] y);
      case (y)
         2'd0:    return occ[2:0];
         2'd1:    return occ[5:3];
         2'd2:    return occ[8:6];
         default: return 3'b111;
      endcase
   endfunction

   // Occupancy of column x, bit k = row k.
   function automatic logic [2:0] col_bits(input logic [8:0] occ, input logic [1:0] x);
      case (x)
         2'd0:    return {occ[6], occ[3], occ[0]};
         2'd1:    return {occ[7], occ[4], occ[1]};
         2'd2:    return {occ[8], occ[5], occ[2]};
         default: return 3'b111;
      endcase
   endfunction

   // Move to the next free position in the given direction; stay if none.
   function automatic logic [1:0] skip_step(input logic [1:0] pos, input logic fwd,
                                            input logic [2:0] occ3);
      logic [1:0] c1;
      logic [1:0] c2;
      c1 = fwd ? wrap_inc(pos) : wrap_dec(pos);
      c2 = fwd ? wrap_inc(c1) : wrap_dec(c1);
      if (!occ3[c1])
         return c1;
      else if (!occ3[c2])
         return c2;
      else
         return pos;
   endfunction

   // Column of a board index.
   function automatic logic [1:0] cell_x(input logic [3:0] idx);
      case (idx)
         4'd0, 4'd3, 4'd6: return 2'd0;
         4'd1, 4'd4, 4'd7: return 2'd1;
         4'd2, 4'd5, 4'd8: return 2'd2;
         default:          return 2'd1;
      endcase
   endfunction

   // Row of a board index.
   function automatic logic [1:0] cell_y(input logic [3:0] idx);
      case (idx)
         4'd0, 4'd1, 4'd2: return 2'd0;
         4'd3, 4'd4, 4'd5: return 2'd1;
         4'd6, 4'd7, 4'd8: return 2'd2;
         default:          return 2'd1;
      endcase
   endfunction
`endif

   assign cur_cell = cell_idx(CurX, CurY);

   // Cursor after a direction button in SEL; only the highest-priority one acts.
   always_comb begin
      nxt_x = CurX;
      nxt_y = CurY;
`ifdef CURSOR_SKIP_EN
      if (BtnU)
         nxt_y = skip_step(CurY, 1'b0, col_bits(Occupied, CurX));
      else if (BtnD)
         nxt_y = skip_step(CurY, 1'b1, col_bits(Occupied, CurX));
      else if (BtnL)
         nxt_x = skip_step(CurX, 1'b0, row_bits(Occupied, CurY));
      else if (BtnR)
         nxt_x = skip_step(CurX, 1'b1, row_bits(Occupied, CurY));
      else begin
         nxt_x = CurX;
         nxt_y = CurY;
      end
`else
      if (BtnU)
         nxt_y = wrap_dec(CurY);
      else if (BtnD)
         nxt_y = wrap_inc(CurY);
      else if (BtnL)
         nxt_x = wrap_dec(CurX);
      else if (BtnR)
         nxt_x = wrap_inc(CurX);
      else begin
         nxt_x = CurX;
         nxt_y = CurY;
      end
`endif
   end

   // Cursor position loaded when leaving IDLE for SEL.
   always_comb begin
      ent_x = 2'd1;
      ent_y = 2'd1;
`ifdef CURSOR_SKIP_EN
      if (Occupied[4]) begin
         // Scan downward so the lowest free index is the one that sticks.
         for (int i = 8; i >= 0; i--) begin
            if (!Occupied[i]) begin
               ent_x = cell_x(4'(i));
               ent_y = cell_y(4'(i));
            end else begin
               ent_x = ent_x;
               ent_y = ent_y;
            end
         end
      end else begin
         ent_x = 2'd1;
         ent_y = 2'd1;
      end
`endif
   end

   // Controller FSM with all outputs registered.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state         <= ST_IDLE;
         CurX          <= 2'd1;
         CurY          <= 2'd1;
         mv.MoveReq    <= 1'b0;
         mv.MoveCell   <= 4'd0;
         mv.MovePlayer <= 1'b0;
         Reject        <= 1'b0;
         Timeout       <= 1'b0;
         to_cnt        <= '0;
      end else begin
         Reject  <= 1'b0;
         Timeout <= 1'b0;
         case (state)
            ST_IDLE: begin
               // A still-high ack from a previous handshake blocks entry.
               if (Enable && !mv.MoveAck) begin
                  state <= ST_SEL;
                  CurX  <= ent_x;
                  CurY  <= ent_y;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_SEL: begin
               if (!Enable) begin
                  state <= ST_IDLE;
               end else if (BtnC) begin
                  if (Occupied[cur_cell]) begin
                     Reject <= 1'b1;
                  end else begin
                     mv.MoveCell   <= cur_cell;
                     mv.MovePlayer <= Turn;
                     mv.MoveReq    <= 1'b1;
                     to_cnt        <= '0;
                     state         <= ST_REQ;
                  end
               end else begin
                  CurX <= nxt_x;
                  CurY <= nxt_y;
               end
            end
            ST_REQ: begin
               // Ack is checked first so it wins over a simultaneous timeout.
               if (mv.MoveAck) begin
                  mv.MoveReq <= 1'b0;
                  state      <= ST_REL;
               end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                  mv.MoveReq <= 1'b0;
                  Timeout    <= 1'b1;
                  to_cnt     <= to_cnt + TO_W'(1);
                  state      <= ST_SEL;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            ST_REL: begin
               if (!mv.MoveAck)
                  state <= Enable ? ST_SEL : ST_IDLE;
               else
                  state <= ST_REL;
            end
            default: begin
               state      <= ST_IDLE;
               mv.MoveReq <= 1'b0;
            end
         endcase
      end
   end

   assign Qidle = state[3];
   assign Qsel  = state[2];
   assign Qreq  = state[1];
   assign Qrel  = state[0];

endmodule

// File: tb/tb_ttt_move_entry.sv
// Self-checking bench for ttt_move_entry: directed scenarios followed by
// randomized buttons, occupancy, enable, ack and async resets, all compared
// every cycle against a behavioural model of the move-entry rules.
module tb_ttt_move_entry;
   localparam int TO_CYC = 7;
   localparam int PH_IDLE = 0;
   localparam int PH_SEL  = 1;
   localparam int PH_REQ  = 2;
   localparam int PH_REL  = 3;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       Enable = 1'b0;
   logic       Turn = 1'b0;
   logic [8:0] Occupied = 9'd0;
   logic       BtnU = 1'b0, BtnD = 1'b0, BtnL = 1'b0, BtnR = 1'b0, BtnC = 1'b0;
   logic       ack = 1'b0;
   logic [1:0] CurX, CurY;
   logic       Reject, Timeout, Qidle, Qsel, Qreq, Qrel;

   int checks = 0;
   int failures = 0;

   // Reference model state
   int m_ph, m_x, m_y, m_cell, m_player, m_req, m_rej, m_to, m_wait;

   ttt_move_entry_if mv ();
   assign mv.MoveAck = ack;

   ttt_move_entry #(.TIMEOUT_CYC(TO_CYC), .TO_W(3)) dut (
      .Clk(Clk), .Reset(Reset), .Enable(Enable), .Turn(Turn), .Occupied(Occupied),
      .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR), .BtnC(BtnC),
      .mv(mv), .CurX(CurX), .CurY(CurY), .Reject(Reject), .Timeout(Timeout),
      .Qidle(Qidle), .Qsel(Qsel), .Qreq(Qreq), .Qrel(Qrel)
   );

   initial forever #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit is_free(int x, int y);
      return Occupied[3 * y + x] == 1'b0;
   endfunction

   // Next free column along the row in direction dir (+1/-1); stay if none.
   function automatic int slide_x(int x, int y, int dir);
      for (int k = 1; k <= 2; k++) begin
         int nx = (x + dir * k + 6) % 3;
         if (is_free(nx, y)) return nx;
      end
      return x;
   endfunction

   function automatic int slide_y(int x, int y, int dir);
      for (int k = 1; k <= 2; k++) begin
         int ny = (y + dir * k + 6) % 3;
         if (is_free(x, ny)) return ny;
      end
      return y;
   endfunction

   task automatic model_reset();
      m_ph = PH_IDLE; m_x = 1; m_y = 1; m_cell = 0; m_player = 0;
      m_req = 0; m_rej = 0; m_to = 0; m_wait = 0;
   endtask

   // One clock of the game-move rules using the inputs present before the edge.
   task automatic model_step();
      int idx;
      m_rej = 0;
      m_to  = 0;
      case (m_ph)
         PH_IDLE: begin
            if (Enable && !ack) begin
               m_ph = PH_SEL; m_x = 1; m_y = 1;
`ifdef CURSOR_SKIP_EN
               if (Occupied[4]) begin
                  for (int i = 8; i >= 0; i--)
                     if (!Occupied[i]) begin m_x = i % 3; m_y = i / 3; end
               end
`endif
            end
         end
         PH_SEL: begin
            if (!Enable) m_ph = PH_IDLE;
            else if (BtnC) begin
               idx = 3 * m_y + m_x;
               if (Occupied[idx]) m_rej = 1;
               else begin
                  m_cell = idx; m_player = int'(Turn); m_req = 1; m_wait = 0; m_ph = PH_REQ;
               end
            end
`ifdef CURSOR_SKIP_EN
            else if (BtnU) m_y = slide_y(m_x, m_y, -1);
            else if (BtnD) m_y = slide_y(m_x, m_y, 1);
            else if (BtnL) m_x = slide_x(m_x, m_y, -1);
            else if (BtnR) m_x = slide_x(m_x, m_y, 1);
`else
            else if (BtnU) m_y = (m_y + 2) % 3;
            else if (BtnD) m_y = (m_y + 1) % 3;
            else if (BtnL) m_x = (m_x + 2) % 3;
            else if (BtnR) m_x = (m_x + 1) % 3;
`endif
         end
         PH_REQ: begin
            if (ack) begin m_req = 0; m_ph = PH_REL; end
            else begin
               m_wait++;
               if (m_wait == TO_CYC) begin m_req = 0; m_to = 1; m_ph = PH_SEL; end
            end
         end
         PH_REL: begin
            if (!ack) m_ph = Enable ? PH_SEL : PH_IDLE;
         end
         default: m_ph = PH_IDLE;
      endcase
   endtask

   task automatic compare_all();
      logic [3:0] q_exp;
      q_exp = 4'b1000 >> m_ph;
      check("req", 32'(mv.MoveReq), m_req);
      check("cell", 32'(mv.MoveCell), m_cell);
      check("player", 32'(mv.MovePlayer), m_player);
      check("curx", 32'(CurX), m_x);
      check("cury", 32'(CurY), m_y);
      check("reject", 32'(Reject), m_rej);
      check("timeout", 32'(Timeout), m_to);
      check("qflags", 32'({Qidle, Qsel, Qreq, Qrel}), 32'(q_exp));
   endtask

   task automatic step(input logic u, input logic d, input logic l, input logic r, input logic c);
      @(negedge Clk);
      BtnU = u; BtnD = d; BtnL = l; BtnR = r; BtnC = c;
      @(posedge Clk);
      model_step();
      #1;
      compare_all();
   endtask

   // Reset pulse between clock edges, checked before any edge arrives.
   task automatic async_reset();
      @(negedge Clk);
      BtnU = 0; BtnD = 0; BtnL = 0; BtnR = 0; BtnC = 0;
      #1 Reset = 1'b1;
      #1;
      model_reset();
      compare_all();
      #1 Reset = 1'b0;
      @(posedge Clk);
      model_step();
      #1;
      compare_all();
   endtask

   initial begin
      int hi, tos, exp_y;
      model_reset();
      #2 Reset = 1'b1;
      #1 compare_all();
      #4 Reset = 1'b0;

      // Move to (2,2) and request cell 8
      Enable = 1; Turn = 1; ack = 0; Occupied = 9'h000;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0);
      check("tp1_curx", 32'(CurX), 32'd2);
      check("tp1_cury", 32'(CurY), 32'd2);
      step(0, 0, 0, 0, 1);
      check("tp1_req", 32'(mv.MoveReq), 32'd1);
      check("tp1_cell", 32'(mv.MoveCell), 32'd8);
      check("tp1_player", 32'(mv.MovePlayer), 32'd1);

      // Ack after 5 request cycles, held 3 cycles
      repeat (4) step(0, 0, 0, 0, 0);
      ack = 1;
      step(0, 0, 0, 0, 0);
      check("ack_req_drop", 32'(mv.MoveReq), 32'd0);
      check("ack_qrel", 32'(Qrel), 32'd1);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      ack = 0;
      step(0, 0, 0, 0, 0);
      check("rel_to_sel", 32'(Qsel), 32'd1);

      // Wrap at the edges, then two buttons in one cycle
      step(0, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0);
      check("at_origin", 32'({CurX, CurY}), 32'd0);
      step(0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      check("wrap_x", 32'(CurX), 32'd2);
      check("wrap_y", 32'(CurY), 32'd2);
      step(1, 0, 0, 1, 0);
      check("prio_x", 32'(CurX), 32'd2);
      check("prio_y", 32'(CurY), 32'd1);

      // Reject on an occupied centre
      step(0, 0, 1, 0, 0);
      Occupied = 9'h010;
      step(0, 0, 0, 0, 1);
      check("rej_pulse", 32'(Reject), 32'd1);
      check("rej_noreq", 32'(mv.MoveReq), 32'd0);
      check("rej_qsel", 32'(Qsel), 32'd1);
      step(0, 0, 0, 0, 0);
      check("rej_once", 32'(Reject), 32'd0);

      // Timeout with no ack
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1);
      hi = mv.MoveReq ? 1 : 0;
      tos = 0;
      for (int i = 0; i < 12; i++) begin
         step(0, 0, 0, 0, 0);
         if (mv.MoveReq) hi++;
         if (Timeout) tos++;
         if (Qsel) break;
      end
      step(0, 0, 0, 0, 0);
      if (Timeout) tos++;
      check("to_req_cycles", hi, TO_CYC);
      check("to_pulses", tos, 1);
      check("to_curx", 32'(CurX), 32'd2);
      check("to_cury", 32'(CurY), 32'd1);

      // Reset in the middle of a request
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      check("pre_rst_req", 32'(mv.MoveReq), 32'd1);
      async_reset();

      // Row 1 full, cursor at (0,0), BtnD
      Occupied = 9'h038;
      Enable = 0;
      step(0, 0, 0, 0, 0);
      Enable = 1;
      step(0, 0, 0, 0, 0);
`ifdef CURSOR_SKIP_EN
      exp_y = 2;
`else
      step(0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      exp_y = 1;
`endif
      check("skip_origin", 32'({CurX, CurY}), 32'd0);
      step(0, 1, 0, 0, 0);
      check("skip_down", 32'(CurY), exp_y);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if (n % 16 == 0) Occupied = 9'($urandom & $urandom);
         Turn = 1'($urandom_range(0, 1));
         Enable = ($urandom_range(0, 19) != 0);
         case (m_ph)
            PH_REQ:  ack = ($urandom_range(0, 4) == 0);
            PH_REL:  ack = ack && ($urandom_range(0, 2) != 0);
            default: ack = ($urandom_range(0, 15) == 0);
         endcase
         if ($urandom_range(0, 299) == 0)
            async_reset();
         else
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ttt_move_entry.md
Name: ttt_move_entry

Overview:
- Player-side move entry controller for the tic-tac-toe game core; the initiator of the move-request interface that the game core's turn states consume.
- Takes single-cycle, already-debounced button pulses, moves a 3x3 cursor and rejects presses on occupied cells.
- Delivers a legal cell index to the game core over a four-phase req/ack handshake.
- Sits between the button debouncers and the game core; the cursor outputs also drive the VGA board overlay.

Parameters:
- TIMEOUT_CYC, 1023: cycles REQ may wait for MoveAck before aborting; range 1..2^TO_W-1.
- TO_W, 10: timeout counter width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Enable  in  1  game core is in a turn state (X or O) and accepts moves.
- Turn  in  1  0 = X to move, 1 = O to move.
- Occupied  in  9  board occupancy; bit i = cell i, where i = 3*y + x.
- BtnU, BtnD, BtnL, BtnR, BtnC  in  1 each  single-cycle button pulses.
- MoveAck  in  1  game core acknowledge, four-phase.
- MoveReq  out  1  move request, held until acknowledged.
- MoveCell  out  4  requested cell index, 0..8.
- MovePlayer  out  1  Turn value latched with the request.
- CurX, CurY  out  2 each  cursor column and row, 0..2.
- Reject  out  1  one-cycle pulse: BtnC pressed on an occupied cell.
- Timeout  out  1  one-cycle pulse: request aborted by timeout.
- Qidle, Qsel, Qreq, Qrel  out  1 each  one-hot state flags.

Behaviour:
- Reset (asynchronous, immediate):
  - state IDLE; CurX = CurY = 1 (centre).
  - MoveReq, MoveCell, MovePlayer, Reject, Timeout all 0; timeout counter 0.
- IDLE:
  - Buttons ignored.
  - Enable=1 and MoveAck=0 -> SEL next cycle; cursor set to centre.
- SEL:
  - Enable=0 -> IDLE; cursor is retained.
  - At most one button acts per cycle. Priority: BtnC > BtnU > BtnD > BtnL > BtnR; lower-priority pulses in the same cycle are dropped.
  - BtnU: CurY-1 mod 3. BtnD: CurY+1 mod 3. BtnL: CurX-1 mod 3. BtnR: CurX+1 mod 3. Edges wrap: 0 -> 2 and 2 -> 0.
  - BtnC on a free cell:
    - registers MoveCell = 3*CurY + CurX and MovePlayer = Turn.
    - clears the timeout counter; -> REQ.
    - MoveReq = 1 from the first REQ cycle (one-cycle latency from BtnC).
  - BtnC on an occupied cell: Reject = 1 for exactly one cycle; stay in SEL.
- REQ:
  - MoveReq = 1; MoveCell and MovePlayer held stable.
  - Buttons and Enable are ignored, so the handshake is never abandoned for Enable.
  - MoveAck=1 -> REL; MoveReq drops on the same edge.
  - Otherwise the counter increments. On the cycle the counter reaches TIMEOUT_CYC: MoveReq -> 0, Timeout pulses once, -> SEL.
  - MoveAck and timeout in the same cycle: ack wins; no Timeout pulse.
- REL:
  - MoveReq = 0; waits for MoveAck = 0.
  - Then -> SEL if Enable=1, else IDLE.
  - Cursor is retained, so the next player starts from the last cursor position.
- Reset mid-handshake: MoveReq drops immediately. The game core must treat loss of MoveReq before MoveAck as a cancel.
- MoveCell is always 0..8; values 9..15 are never driven.
- Exactly one Q flag is high at all times.

Optional Feature:
- Macro CURSOR_SKIP_EN.
- Defined:
  - BtnL/BtnR step along the row, wrapping, to the next free cell. If no other cell in the row is free, the cursor does not move.
  - BtnU/BtnD do the same along the column.
  - On entry to SEL, if the centre is occupied, the cursor goes to the lowest-index free cell.
  - Reject can still fire, because the occupancy may change while the cursor rests on a cell.
- Undefined: plain modulo-3 stepping as described above; occupancy affects only the BtnC check.

Test Plan:
- Reset, Enable=1, Occupied=0, BtnR, BtnD, BtnC -> CurX=2, CurY=2; MoveReq high one cycle after BtnC with MoveCell=8 and MovePlayer=Turn.
- Cursor at (0,0): BtnL then BtnU -> CurX=2, CurY=2 (wrap); BtnU and BtnR pulsed in the same cycle -> only CurY changes.
- Occupied=9'h010, cursor at centre, BtnC -> Reject pulses exactly 1 cycle, MoveReq stays 0, Qsel=1.
- REQ with MoveAck raised after 5 cycles -> MoveReq falls on that edge, Qrel=1. Hold MoveAck 3 cycles, drop it with Enable=1 -> Qsel=1; Timeout never pulses.
- TIMEOUT_CYC=4 and MoveAck never asserted -> MoveReq high exactly 4 cycles, Timeout pulses once, return to SEL with cursor unchanged.
- Assert Reset during REQ -> MoveReq=0, Qidle=1, CurX=CurY=1 without waiting for a clock edge.
- With CURSOR_SKIP_EN, Occupied=9'h038 (row 1 full), cursor at (0,0): BtnD -> CurY=2. Without the macro, the same stimulus -> CurY=1.
